geofence_n: RTL and testbench

GEOFENCE_N -- requirements
Module: geofence_n

---
 rtl/geofence_pkg.sv | 17 +
 rtl/geo_cross.sv | 31 +++
 rtl/geofence_n.sv | 172 +++++++++++++++++
 tb/tb_geofence_n.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/geofence_pkg.sv
// Shared types and sizing helpers for the convex-polygon geofence.
`timescale 1ns/1ps
package geofence_pkg;

    typedef enum logic [1:0] {READ, SORT, CHECK, OUT} state_t;

    localparam int NV_MIN = 3;
    localparam int NV_MAX = 8;
    localparam int CW_MIN = 4;
    localparam int CW_MAX = 16;

    // Two (CW+1)-bit signed products subtracted need one extra bit of headroom.
    function automatic int cross_width(input int cw);
        return 2 * cw + 3;
    endfunction

endpackage

// File: rtl/geo_cross.sv
// Combinational signed 2-D cross product a.x*b.y - a.y*b.x on (CW+1)-bit differences.
`timescale 1ns/1ps
module geo_cross
    import geofence_pkg::*;
#(
    parameter int CW = 10,
    localparam int XW = cross_width(CW)
) (
    input  logic signed [CW:0]   ax,
    input  logic signed [CW:0]   ay,
    input  logic signed [CW:0]   bx,
    input  logic signed [CW:0]   by,
    output logic signed [XW-1:0] prod
);

    localparam int PW = 2 * CW + 2;

    logic signed [PW-1:0] ax_ext, ay_ext, bx_ext, by_ext;
    logic signed [PW-1:0] p1, p2;

    always_comb begin
        ax_ext = {{(CW + 1){ax[CW]}}, ax};
        ay_ext = {{(CW + 1){ay[CW]}}, ay};
        bx_ext = {{(CW + 1){bx[CW]}}, bx};
        by_ext = {{(CW + 1){by[CW]}}, by};
        p1     = ax_ext * by_ext;
        p2     = ay_ext * bx_ext;
        prod   = {p1[PW-1], p1} - {p2[PW-1], p2};
    end

endmodule

// File: rtl/geofence_n.sv
// Point-in-convex-polygon test: reads target + NV vertices, sorts them CCW around V0,
// then checks the sign of every edge cross product against the target.
`timescale 1ns/1ps
module geofence_n
    import geofence_pkg::*;
#(
    parameter int NV = 6,
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    output logic          busy,
    output logic          valid,
    output logic          is_inside,
    output logic          on_edge
);

    localparam int XW = cross_width(CW);
    localparam int VW = $clog2(NV);
    localparam int IW = $clog2(NV + 1);
    localparam logic [VW-1:0] IDX_LAST = VW'(NV - 1);
    localparam logic [VW-1:0] IDX_PEN  = VW'(NV - 2);
    localparam logic [IW-1:0] CNT_LAST = IW'(NV);

    state_t         state_reg;
    logic [IW-1:0]  cnt_reg;
    logic [VW-1:0]  si_reg, sj_reg, k_reg;
    logic           pos_reg, neg_reg, zero_reg;
    logic           valid_reg, inside_reg, edge_reg;

    // Sample storage is deliberately left out of reset.
    logic [CW-1:0]  vx_mem [NV];
    logic [CW-1:0]  vy_mem [NV];
    logic [CW-1:0]  tx_reg, ty_reg;

    logic [VW-1:0]        k_next_idx, wr_idx;
    logic signed [CW:0]   ax, ay, bx, by;
    logic signed [XW-1:0] c;
    logic                 c_neg, c_zero, c_pos;

    function automatic logic signed [CW:0] diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    // One multiplier pair serves both phases: pivot-relative angle compare in SORT,
    // edge-vs-target orientation in CHECK.
    always_comb begin
        k_next_idx = (k_reg == IDX_LAST) ? '0 : k_reg + 1'b1;
        wr_idx     = VW'(cnt_reg - 1'b1);
        ax = '0;
        ay = '0;
        bx = '0;
        by = '0;
        if (state_reg == SORT) begin
            ax = diff(vx_mem[si_reg], vx_mem[0]);
            ay = diff(vy_mem[si_reg], vy_mem[0]);
            bx = diff(vx_mem[sj_reg], vx_mem[0]);
            by = diff(vy_mem[sj_reg], vy_mem[0]);
        end else begin
            ax = diff(vx_mem[k_reg], tx_reg);
            ay = diff(vy_mem[k_reg], ty_reg);
            bx = diff(vx_mem[k_next_idx], vx_mem[k_reg]);
            by = diff(vy_mem[k_next_idx], vy_mem[k_reg]);
        end
    end

    geo_cross #(.CW(CW)) u_cross (
        .ax   (ax),
        .ay   (ay),
        .bx   (bx),
        .by   (by),
        .prod (c)
    );

    assign c_neg  = c[XW-1];
    assign c_zero = (c == '0);
    assign c_pos  = !c_neg && !c_zero;

    always_ff @(posedge clk) begin
        if (state_reg == READ && in_valid) begin
            if (cnt_reg == '0) begin
                tx_reg <= X;
                ty_reg <= Y;
            end else begin
                vx_mem[wr_idx] <= X;
                vy_mem[wr_idx] <= Y;
            end
        end else if (state_reg == SORT && c_neg) begin
            vx_mem[si_reg] <= vx_mem[sj_reg];
            vy_mem[si_reg] <= vy_mem[sj_reg];
            vx_mem[sj_reg] <= vx_mem[si_reg];
            vy_mem[sj_reg] <= vy_mem[si_reg];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= READ;
            cnt_reg    <= '0;
            si_reg     <= '0;
            sj_reg     <= '0;
            k_reg      <= '0;
            pos_reg    <= 1'b0;
            neg_reg    <= 1'b0;
            zero_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            inside_reg <= 1'b0;
            edge_reg   <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                READ: begin
                    if (in_valid) begin
                        if (cnt_reg == CNT_LAST) begin
                            cnt_reg   <= '0;
                            si_reg    <= VW'(1);
                            sj_reg    <= VW'(2);
                            state_reg <= SORT;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                SORT: begin
                    if (sj_reg == IDX_LAST) begin
                        if (si_reg == IDX_PEN) begin
                            k_reg     <= '0;
                            pos_reg   <= 1'b0;
                            neg_reg   <= 1'b0;
                            zero_reg  <= 1'b0;
                            state_reg <= CHECK;
                        end else begin
                            si_reg <= si_reg + 1'b1;
                            sj_reg <= si_reg + VW'(2);
                        end
                    end else begin
                        sj_reg <= sj_reg + 1'b1;
                    end
                end
                CHECK: begin
                    pos_reg  <= pos_reg  | c_pos;
                    neg_reg  <= neg_reg  | c_neg;
                    zero_reg <= zero_reg | c_zero;
                    if (k_reg == IDX_LAST) begin
                        state_reg <= OUT;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                OUT: begin
                    valid_reg  <= 1'b1;
                    inside_reg <= !zero_reg && !(pos_reg && neg_reg);
                    edge_reg   <= zero_reg && !(pos_reg && neg_reg);
                    si_reg     <= '0;
                    sj_reg     <= '0;
                    k_reg      <= '0;
                    state_reg  <= READ;
                end
                default: state_reg <= READ;
            endcase
        end
    end

    assign busy      = (state_reg != READ);
    assign valid     = valid_reg;
    assign is_inside = inside_reg;
    assign on_edge   = edge_reg;

endmodule

// File: tb/tb_geofence_n.sv
// Scoreboard bench: three geofence instances (hexagon, square, wide triangle) driven with directed jobs.
`timescale 1ns/1ps
module tb_geofence_n;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  iv, bsy, vld, ins, edg;
    logic [9:0]  x_a, y_a, x_b, y_b;
    logic [11:0] x_c, y_c;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int    dut;
        int    due;
        bit    ins;
        bit    edg;
        string tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int hex_pts[12] = '{100, 50, 0, 50, 75, 93, 25, 7, 25, 93, 75, 7};
    int sq_pts[8]   = '{0, 0, 100, 100, 100, 0, 0, 100};
    int tri_pts[6]  = '{0, 0, 4095, 0, 0, 4095};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    geofence_n #(.NV(6), .CW(10)) u_hex (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .X(x_a), .Y(y_a),
        .busy(bsy[0]), .valid(vld[0]), .is_inside(ins[0]), .on_edge(edg[0])
    );
    geofence_n #(.NV(4), .CW(10)) u_sq (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .X(x_b), .Y(y_b),
        .busy(bsy[1]), .valid(vld[1]), .is_inside(ins[1]), .on_edge(edg[1])
    );
    geofence_n #(.NV(3), .CW(12)) u_tri (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .X(x_c), .Y(y_c),
        .busy(bsy[2]), .valid(vld[2]), .is_inside(ins[2]), .on_edge(edg[2])
    );

    function automatic int nv_of(input int d);
        return (d == 0) ? 6 : (d == 1) ? 4 : 3;
    endfunction

    // Sort pairs + edge checks + output cycle.
    function automatic int lat_of(input int d);
        int n;
        n = nv_of(d);
        return (n - 1) * (n - 2) / 2 + n + 1;
    endfunction

    function automatic int pt(input int d, input int idx);
        if (d == 0) return hex_pts[idx];
        if (d == 1) return sq_pts[idx];
        return tri_pts[idx];
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input bit v, input int x, input int y);
        iv    = '0;
        iv[d] = v;
        case (d)
            0:       begin x_a = 10'(x); y_a = 10'(y); end
            1:       begin x_b = 10'(x); y_b = 10'(y); end
            default: begin x_c = 12'(x); y_c = 12'(y); end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain job; 1: gapped in_valid in READ and held high while busy; 2: reset in 3rd SORT cycle.
    task automatic job(input int d, input string tag, input int tx, input int ty,
                       input bit exp_in, input bit exp_ed, input int mode);
        int acc;
        drive(d, 1'b1, tx, ty);
        step();
        for (int i = 0; i < nv_of(d); i++) begin
            if (mode == 1) begin
                drive(d, 1'b0, 999, 999);
                step();
            end
            drive(d, 1'b1, pt(d, 2 * i), pt(d, 2 * i + 1));
            step();
        end
        acc = cyc;
        if (mode == 2) begin
            drive(d, 1'b0, 0, 0);
            step();
            step();
            reset = 1'b1;
            #1;
            check({tag, ".rst_valid"}, int'(vld[d]), 0);
            check({tag, ".rst_busy"}, int'(bsy[d]), 0);
            step();
            reset = 1'b0;
            step();
            $display("job %s: dut=%0d aborted by reset", tag, d);
            return;
        end
        sb.push_back('{dut: d, due: acc + lat_of(d), ins: exp_in, edg: exp_ed, tag: tag});
        if (mode == 1) begin
            drive(d, 1'b1, 999, 999);
            for (int k = 0; k < lat_of(d); k++) begin
                check({tag, ".busy_high"}, int'(bsy[d]), 1);
                step();
            end
            check({tag, ".busy_low"}, int'(bsy[d]), 0);
        end
        drive(d, 1'b0, 0, 0);
        for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clk);
        if (sb.size() != 0) begin
            check({tag, ".timeout"}, sb.size(), 0);
            sb.delete();
        end
        #1;
        repeat (3) step();
        check({tag, ".hold_inside"}, int'(ins[d]), int'(exp_in));
        check({tag, ".hold_edge"}, int'(edg[d]), int'(exp_ed));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                if (vld[d]) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", int'(vld[d]), 0);
                    end else begin
                        mon_e = sb.pop_front();
                        check({mon_e.tag, ".dut"}, d, mon_e.dut);
                        check({mon_e.tag, ".cycle"}, cyc, mon_e.due);
                        check({mon_e.tag, ".inside"}, int'(ins[d]), int'(mon_e.ins));
                        check({mon_e.tag, ".on_edge"}, int'(edg[d]), int'(mon_e.edg));
                        check({mon_e.tag, ".exclusive"}, int'(ins[d] & edg[d]), 0);
                        $display("job %s: dut=%0d inside=%0d on_edge=%0d cycle=%0d",
                                 mon_e.tag, d, ins[d], edg[d], cyc);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        iv    = '0;
        x_a = '0; y_a = '0; x_b = '0; y_b = '0; x_c = '0; y_c = '0;
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            check("reset.busy", int'(bsy[d]), 0);
            check("reset.valid", int'(vld[d]), 0);
            check("reset.inside", int'(ins[d]), 0);
            check("reset.on_edge", int'(edg[d]), 0);
        end
        reset = 1'b0;
        step();

        job(0, "hex_in",          50,   50,   1'b1, 1'b0, 0);
        job(0, "hex_out",         500,  500,  1'b0, 1'b0, 0);
        job(0, "hex_edge",        50,   7,    1'b0, 1'b1, 0);
        job(1, "sq_edge",         50,   0,    1'b0, 1'b1, 0);
        job(1, "sq_vertex",       0,    0,    1'b0, 1'b1, 0);
        job(1, "sq_in",           50,   50,   1'b1, 1'b0, 0);
        job(1, "sq_out",          101,  50,   1'b0, 1'b0, 0);
        job(2, "tri_in",          1,    1,    1'b1, 1'b0, 0);
        job(2, "tri_out",         4095, 4095, 1'b0, 1'b0, 0);
        job(2, "tri_edge",        2000, 2095, 1'b0, 1'b1, 0);
        job(0, "hex_gapped",      50,   50,   1'b1, 1'b0, 1);
        job(0, "hex_abort",       50,   50,   1'b0, 1'b0, 2);
        job(0, "hex_after_abort", 60,   40,   1'b1, 1'b0, 0);

        repeat (30) step();
        check("final.queue_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
